// File: rtl/fir_filter_shared_param.sv
// fir_filter_shared_param
//   Resource-shared FIR filter: a single multiplier-accumulator walks the taps
//   one per clock. It takes samples over a valid/ready input port and hands
//   results out over a valid/ready output port. Coefficients are loaded in
//   bursts, and each burst is checked for the correct length.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
//   valid && ready are both high. Once valid is raised, the source holds it and
//   its data stable until that transfer. s_ready is combinational; m_valid is
//   held in a register.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   x_in       input sample (unsigned, DATA_W)
//   s_valid    x_in valid
//   s_ready    block accepts a sample this cycle
//   coef_val   coefficient write data (unsigned, COEF_W)
//   writeen    coefficient write strobe
//   tlast      marks the last coefficient of a load burst
//   coef_ok    a complete coefficient set is loaded
//   coef_err   sticky: the last burst had the wrong length
//   y_out      filter result (OUT_W)
//   m_valid    y_out valid
//   m_ready    downstream accepts y_out
//   state_dbg  current FSM state (0=LOAD 1=IDLE 2=MAC 3=OUT)
module fir_filter_shared_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 7,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] coef_val,
  input  logic              writeen,
  input  logic              tlast,
  output logic              coef_ok,
  output logic              coef_err,
  output logic [OUT_W-1:0]  y_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        state_dbg
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int TAP_W  = $clog2(NTAPS);
  // The load counter must be able to represent NTAPS+1 so that over-long
  // bursts saturate at a value that never compares equal to NTAPS.
  localparam int LD_W   = $clog2(NTAPS + 2);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [COEF_W-1:0]   coef  [NTAPS];
  logic [DATA_W-1:0]   xline [NTAPS];
  logic [OUT_W-1:0]    acc;
  logic [TAP_W-1:0]    tap;
  logic [LD_W-1:0]     ld_cnt;
  logic                in_burst;

  logic                wr_acc;
  logic                accept;
  logic                last_tap;
  logic                cnt_ok;
  logic [LD_W-1:0]     ld_next;
  logic [LD_W-1:0]     ld_idx;
  logic [DATA_W-1:0]   x_sel;
  logic [COEF_W-1:0]   c_sel;
  logic [PROD_W-1:0]   prod;
  logic [OUT_W-1:0]    acc_sum;

  assign state_dbg = state;
  assign m_valid   = (state == S_OUT);
  assign s_ready   = (state == S_IDLE) && coef_ok && !writeen;
  assign accept    = s_valid && s_ready;
  // Coefficient writes are only honoured while no sample is being processed.
  assign wr_acc    = writeen && ((state == S_LOAD) || (state == S_IDLE));
  assign last_tap  = (tap == TAP_W'(NTAPS - 1));

  // A write outside a burst starts a new one at index 0. Inside a burst the
  // count climbs and saturates at NTAPS+1; writes at index >= NTAPS land nowhere.
  always_comb begin
    ld_idx  = in_burst ? ld_cnt : '0;
    ld_next = LD_W'(1);
    if (in_burst) begin
      if (ld_cnt == LD_W'(NTAPS + 1)) ld_next = ld_cnt;
      else                            ld_next = ld_cnt + LD_W'(1);
    end
    cnt_ok = (ld_next == LD_W'(NTAPS));
  end

  // Tap multiplexers feeding the shared multiplier.
  always_comb begin
    x_sel = '0;
    c_sel = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (tap == TAP_W'(k)) begin
        x_sel = xline[k];
        c_sel = coef[k];
      end
    end
    prod    = {{COEF_W{1'b0}}, x_sel} * {{DATA_W{1'b0}}, c_sel};
    acc_sum = acc + OUT_W'(prod);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nx;
  end

  // FSM next state. A coefficient write in IDLE wins over a sample.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD, S_IDLE: begin
        if (wr_acc)      state_nx = (tlast && cnt_ok) ? S_IDLE : S_LOAD;
        else if (accept) state_nx = S_MAC;
      end
      S_MAC:   if (last_tap) state_nx = S_OUT;
      S_OUT:   if (m_ready)  state_nx = S_IDLE;
      default: state_nx = S_LOAD;
    endcase
  end

  // Datapath: coefficient store, delay line, accumulator, result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef[k]  <= '0;
        xline[k] <= '0;
      end
      acc      <= '0;
      tap      <= '0;
      y_out    <= '0;
      ld_cnt   <= '0;
      in_burst <= 1'b0;
      coef_ok  <= 1'b0;
      coef_err <= 1'b0;
    end else begin
      if (wr_acc) begin
        for (int k = 0; k < NTAPS; k++) begin
          if (ld_idx == LD_W'(k)) coef[k] <= coef_val;
        end
        ld_cnt <= ld_next;
        if (tlast) begin
          in_burst <= 1'b0;
          coef_ok  <= cnt_ok;
          coef_err <= !cnt_ok;
        end else begin
          in_burst <= 1'b1;
          coef_ok  <= 1'b0;
          coef_err <= 1'b0;
        end
      end

      if (accept) begin
        xline[0] <= x_in;
        for (int k = 1; k < NTAPS; k++) xline[k] <= xline[k-1];
        acc <= '0;
        tap <= '0;
      end

      if (state == S_MAC) begin
        acc <= acc_sum;
        if (last_tap) y_out <= acc_sum;
        else          tap   <= tap + TAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_shared_param.sv
// Directed testbench for fir_filter_shared_param at its default parameters.
module tb_fir_filter_shared_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int NTAPS  = 7;
  localparam int OUT_W  = 19;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] x_in;
  logic              s_valid;
  logic              s_ready;
  logic [COEF_W-1:0] coef_val;
  logic              writeen;
  logic              tlast;
  logic              coef_ok;
  logic              coef_err;
  logic [OUT_W-1:0]  y_out;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  fir_filter_shared_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .x_in(x_in), .s_valid(s_valid), .s_ready(s_ready),
    .coef_val(coef_val), .writeen(writeen), .tlast(tlast),
    .coef_ok(coef_ok), .coef_err(coef_err),
    .y_out(y_out), .m_valid(m_valid), .m_ready(m_ready),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  int cv[16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Writes cv[0..n-1], tlast on the last one. Starts and ends at posedge+1.
  task automatic write_burst(input int n);
    for (int i = 0; i < n; i++) begin
      writeen  = 1'b1;
      coef_val = cv[i][COEF_W-1:0];
      tlast    = (i == n - 1);
      @(posedge clk); #1;
    end
    writeen = 1'b0;
    tlast   = 1'b0;
  endtask

  // Pushes one sample, checks latency and result against the head of exp_q,
  // optionally holds backpressure for 'hold' cycles and strobes writeen for the
  // first 'wr_cycles' MAC cycles.
  task automatic push(input int x, input int hold, input int wr_cycles, input string tag);
    int cnt;
    logic [OUT_W-1:0] exp_y;
    cnt = 0;
    while (!s_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_rdy"}, 64'(s_ready), 64'(1));
    exp_y   = exp_q.pop_front();
    m_ready = (hold == 0);
    x_in    = x[DATA_W-1:0];
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    x_in    = '0;
    cnt = 0;
    while (!m_valid && cnt < 20) begin
      writeen  = (cnt < wr_cycles);
      coef_val = 8'd99;
      tlast    = 1'b1;
      @(posedge clk); #1; cnt++;
    end
    writeen = 1'b0;
    tlast   = 1'b0;
    check({tag, "_lat"}, 64'(cnt), 64'(NTAPS));
    check({tag, "_y"}, 64'(y_out), 64'(exp_y));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_y"}, 64'(y_out), 64'(exp_y));
        check({tag, "_hold_v"}, 64'(m_valid), 64'(1));
        check({tag, "_hold_rdy"}, 64'(s_ready), 64'(0));
      end
      m_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_vdrop"}, 64'(m_valid), 64'(0));
    check({tag, "_rdy_after"}, 64'(s_ready), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; x_in = '0; s_valid = 1'b0; coef_val = '0;
    writeen = 1'b0; tlast = 1'b0; m_ready = 1'b1;
    #12;
    check("rst_mvalid", 64'(m_valid), 64'(0));
    check("rst_ok", 64'(coef_ok), 64'(0));
    check("rst_err", 64'(coef_err), 64'(0));
    check("rst_y", 64'(y_out), 64'(0));
    check("rst_sready", 64'(s_ready), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(ST_LOAD));
    rst = 1'b1;
    @(posedge clk); #1;

    // Load 10..70 and run an impulse response.
    for (int i = 0; i < 7; i++) cv[i] = 10 * (i + 1);
    write_burst(7);
    check("load1_ok", 64'(coef_ok), 64'(1));
    check("load1_err", 64'(coef_err), 64'(0));
    check("load1_state", 64'(state_dbg), 64'(ST_IDLE));
    for (int k = 0; k < 20; k++) exp_q.push_back((k < 7) ? OUT_W'(10 * (k + 1)) : '0);
    for (int k = 0; k < 20; k++) push((k == 0) ? 1 : 0, 0, 0, "impulse");

    // Full scale: all coefficients 255, eight samples of 255.
    for (int i = 0; i < 7; i++) cv[i] = 255;
    write_burst(7);
    check("load255_ok", 64'(coef_ok), 64'(1));
    for (int k = 1; k <= 8; k++) exp_q.push_back(OUT_W'(((k < 7) ? k : 7) * 65025));
    for (int k = 0; k < 8; k++) push(255, 0, 0, "fullscale");

    // Backpressure for 10 cycles.
    exp_q.push_back(OUT_W'(455175));
    push(255, 10, 0, "bp");

    // Short burst (5 writes).
    for (int i = 0; i < 5; i++) cv[i] = 3;
    write_burst(5);
    check("short_err", 64'(coef_err), 64'(1));
    check("short_ok", 64'(coef_ok), 64'(0));
    check("short_sready", 64'(s_ready), 64'(0));
    check("short_state", 64'(state_dbg), 64'(ST_LOAD));
    // A sample offered now must be ignored.
    x_in = 8'd100; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ign_state", 64'(state_dbg), 64'(ST_LOAD));
    end
    s_valid = 1'b0; x_in = '0;

    // Long burst (9 writes).
    for (int i = 0; i < 9; i++) cv[i] = 4;
    write_burst(9);
    check("long_err", 64'(coef_err), 64'(1));
    check("long_ok", 64'(coef_ok), 64'(0));

    // Correct reload 1..7; delay line is still all 255.
    for (int i = 0; i < 7; i++) cv[i] = i + 1;
    write_burst(7);
    check("reload_err", 64'(coef_err), 64'(0));
    check("reload_ok", 64'(coef_ok), 64'(1));
    exp_q.push_back(OUT_W'(6886));   // 1*1 + 255*(2+..+7)
    push(1, 0, 0, "reload_a");
    exp_q.push_back(OUT_W'(6379));   // 2*1 + 1*2 + 255*(3+..+7)
    push(2, 0, 0, "reload_b");

    // writeen during MAC is ignored.
    exp_q.push_back(OUT_W'(5620));   // 3*1+2*2+1*3 + 255*(4+..+7)
    push(3, 0, 3, "wr_in_mac");
    check("wr_in_mac_ok", 64'(coef_ok), 64'(1));
    check("wr_in_mac_err", 64'(coef_err), 64'(0));

    // writeen together with s_valid in IDLE: write wins.
    writeen = 1'b1; coef_val = 8'd50; tlast = 1'b0;
    s_valid = 1'b1; x_in = 8'd9;
    #1;
    check("collide_sready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    s_valid = 1'b0; x_in = '0;
    check("collide_state", 64'(state_dbg), 64'(ST_LOAD));
    check("collide_ok", 64'(coef_ok), 64'(0));
    check("collide_mvalid", 64'(m_valid), 64'(0));
    for (int i = 0; i < 6; i++) cv[i] = i + 2;
    write_burst(6);
    check("collide_reload_ok", 64'(coef_ok), 64'(1));
    exp_q.push_back(OUT_W'(4806));   // 4*50+3*2+2*3+1*4 + 255*(5+6+7)
    push(4, 0, 0, "collide_y");

    // Asynchronous reset in the middle of MAC (tap=3).
    x_in = 8'd5; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; x_in = '0;
    check("mid_state", 64'(state_dbg), 64'(ST_MAC));
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_mvalid", 64'(m_valid), 64'(0));
    check("arst_y", 64'(y_out), 64'(0));
    check("arst_ok", 64'(coef_ok), 64'(0));
    check("arst_err", 64'(coef_err), 64'(0));
    check("arst_sready", 64'(s_ready), 64'(0));
    check("arst_state", 64'(state_dbg), 64'(ST_LOAD));
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 64'(state_dbg), 64'(ST_LOAD));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
